// File: rtl/regw_commit_queue_if.sv
// Commit-stream handshake bundle.
// Carries one retired-instruction record plus valid/ready.
interface regw_commit_queue_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            commit;
  logic [XLEN-1:0] pre_pc;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic            ready;

  modport master (
    output commit, pre_pc, instr, pc,
    input  ready
  );

  modport slave (
    input  commit, pre_pc, instr, pc,
    output ready
  );
endinterface

// File: rtl/regw_commit_queue.sv
// Small FIFO between the M stage commit flag and the
// retirement consumer, with a retired-instruction counter.
module regw_commit_queue #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  regw_commit_queue_if.slave   in_bus,
  regw_commit_queue_if.master  out_bus,
  input  logic                 flush,
  output logic [AW:0]          count,
  output logic [CNT_W-1:0]     retire_cnt
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0] pre_pc_q [DEPTH];
  logic [ILEN-1:0] instr_q  [DEPTH];
  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            push;
  logic            pop;
  logic            valid;

  // Handshake: a full queue still accepts when the head leaves.
  always_comb begin
    valid         = (count != '0);
    in_bus.ready  = (count < FULL) | out_bus.ready;
    push          = in_bus.commit & in_bus.ready & ~flush;
    pop           = valid & out_bus.ready & ~flush;
  end

  // Head record, forced to zero while the queue is empty.
  always_comb begin
    out_bus.commit = valid;
    out_bus.pre_pc = valid ? pre_pc_q[head] : '0;
    out_bus.instr  = valid ? instr_q[head]  : '0;
    out_bus.pc     = valid ? pc_q[head]     : '0;
  end

  // Entry storage; only valid slots are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      pre_pc_q[tail] <= in_bus.pre_pc;
      instr_q[tail]  <= in_bus.instr;
      pc_q[tail]     <= in_bus.pc;
    end
  end

  // Pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Retired-instruction counter; survives flush, wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     retire_cnt <= '0;
    else if (pop) retire_cnt <= retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_regw_commit_queue.sv
// Randomized bench for regw_commit_queue against a
// queue-based reference model.
module tb_regw_commit_queue;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [XLEN-1:0] pre_pc;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  count;
  logic [63:0] retire_cnt;
  logic [2:0]  count_w;
  logic [3:0]  retire_w;

  regw_commit_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) in_if ();
  regw_commit_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) out_if ();
  regw_commit_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) in_w ();
  regw_commit_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) out_w ();

  regw_commit_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .CNT_W(64)
  ) dut (
    .clk(clk), .rst(rst), .in_bus(in_if), .out_bus(out_if),
    .flush(flush), .count(count), .retire_cnt(retire_cnt)
  );

  regw_commit_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .CNT_W(4)
  ) dut_w (
    .clk(clk), .rst(rst), .in_bus(in_w), .out_bus(out_w),
    .flush(flush), .count(count_w), .retire_cnt(retire_w)
  );

  assign in_w.commit = in_if.commit;
  assign in_w.pre_pc = in_if.pre_pc;
  assign in_w.instr  = in_if.instr;
  assign in_w.pc     = in_if.pc;
  assign out_w.ready = out_if.ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        mq[$];
  logic [63:0] m_retire = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out();
    ent_t h;
    logic v;
    v = (mq.size() > 0);
    h = '{default: '0};
    if (v) h = mq[0];
    check("out_commit", 64'(out_if.commit), 64'(v));
    check("out_pre_pc", out_if.pre_pc, h.pre_pc);
    check("out_instr",  64'(out_if.instr), 64'(h.instr));
    check("out_pc",     out_if.pc, h.pc);
    check("count",      64'(count), 64'(mq.size()));
    check("retire_cnt", retire_cnt, m_retire);
    check("count_w",    64'(count_w), 64'(mq.size()));
    check("retire_w",   64'(retire_w), m_retire & 64'hF);
  endtask

  task automatic step(input logic c, input logic fl,
                      input logic ordy, input ent_t e);
    logic exp_rdy, push, pop;
    @(negedge clk);
    in_if.commit = c;
    in_if.pre_pc = e.pre_pc;
    in_if.instr  = e.instr;
    in_if.pc     = e.pc;
    out_if.ready = ordy;
    flush        = fl;
    #1;
    exp_rdy = (mq.size() < DEPTH) || ordy;
    check("in_ready", 64'(in_if.ready), 64'(exp_rdy));
    push = c && exp_rdy && !fl;
    pop  = (mq.size() > 0) && ordy && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (pop) begin
        void'(mq.pop_front());
        m_retire++;
      end
      if (push) mq.push_back(e);
    end
    #1;
    check_out();
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pre_pc = {$urandom, $urandom};
    e.instr  = $urandom;
    e.pc     = {$urandom, $urandom};
    return e;
  endfunction

  task automatic rstep(input logic c, input logic fl, input logic ordy);
    step(c, fl, ordy, rnd_ent());
  endtask

  initial begin
    ent_t e0;
    rst          = 1'b0;
    flush        = 1'b0;
    in_if.commit = 1'b0;
    in_if.pre_pc = '0;
    in_if.instr  = '0;
    in_if.pc     = '0;
    out_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_if.ready), 64'd1);
    check_out();
    @(negedge clk);
    rst = 1'b1;

    // Single entry, pushed on the first edge after reset
    e0.pre_pc = 64'h8000_0000;
    e0.instr  = 32'h0000_0013;
    e0.pc     = 64'h8000_0004;
    step(1'b1, 1'b0, 1'b1, e0);
    check("single_instr", 64'(out_if.instr), 64'h13);
    rstep(1'b0, 1'b0, 1'b1);
    check("single_retire", retire_cnt, 64'd1);

    // Fill, hold, then drain in order
    repeat (4) rstep(1'b1, 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'd4);
    rstep(1'b1, 1'b0, 1'b0);
    repeat (4) rstep(1'b0, 1'b0, 1'b1);
    check("drain_count", 64'(count), 64'd0);

    // Full with simultaneous push and pop, across the wrap
    repeat (4) rstep(1'b1, 1'b0, 1'b0);
    repeat (6) rstep(1'b1, 1'b0, 1'b1);
    check("full_pp_count", 64'(count), 64'd4);

    // Flush at count 3 while pushing
    rstep(1'b0, 1'b0, 1'b1);
    check("pre_flush_count", 64'(count), 64'd3);
    rstep(1'b1, 1'b1, 1'b1);
    check("flush_commit", 64'(out_if.commit), 64'd0);

    // Async reset between edges with two entries queued
    repeat (2) rstep(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_if.commit = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    m_retire = '0;
    check("arst_in_ready", 64'(in_if.ready), 64'd1);
    check_out();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic; wrap counter sees many 16-pop wraps
    for (int i = 0; i < 500; i++) begin
      rstep($urandom_range(0, 9) < 7,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
